sdram_traffic_gen: RTL

Synthesizable, parametrised SDRAM traffic generator and checker that sits in front of the `sdram` controller in place of bench-side stimulus. It writes NUM_BURSTS bursts of a deterministic address-derived pattern through the controller's burst-write handshake, then reads the region back and compares every word. It reports error count, first failing address and timeout status, so the same block serves as simulation stimulus and on-board memory self-test.

---
 rtl/sdram_traffic_gen_if.sv | 35 +++
 rtl/sdram_traffic_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_traffic_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_traffic_gen_if
// Description : Burst request/response bus between the traffic generator
//               (master) and the SDRAM controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_traffic_gen_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned COL_W     = 9,
    parameter int unsigned ROW_W     = 14,
    parameter int unsigned BA_W      = 3
);
    logic [BA_W-1:0]             ba;
    logic [ROW_W-1:0]            row;
    logic [COL_W-1:0]            col;
    logic                        wr_req;
    logic [DATA_W*BURST_LEN-1:0] wr_data;
    logic                        wr_ack;
    logic                        rd_req;
    logic                        rd_valid;
    logic [DATA_W-1:0]           rd_data;

    modport master (
        output ba, row, col, wr_req, wr_data, rd_req,
        input  wr_ack, rd_valid, rd_data
    );

    modport slave (
        input  ba, row, col, wr_req, wr_data, rd_req,
        output wr_ack, rd_valid, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/sdram_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : sdram_traffic_gen
// Description : Writes NUM_BURSTS bursts of an address-derived pattern and
//               reads them back, counting mismatches. Optional pattern
//               inversion is enabled by defining SDRAM_TG_INVERT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_traffic_gen #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned COL_W      = 9,
    parameter int unsigned ROW_W      = 14,
    parameter int unsigned BA_W       = 3,
    parameter int unsigned NUM_BURSTS = 1024,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  wire logic                        sclk,
    input  wire logic                        srst,
    input  wire logic                        start,
    input  wire logic [1:0]                  mode,
    input  wire logic                        invert,
    sdram_traffic_gen_if.master              mem,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic                             timeout,
    output logic [15:0]                      err_cnt,
    output logic [BA_W+ROW_W+COL_W-1:0]      first_err_addr
);

    localparam int unsigned c_ADDR_W  = BA_W + ROW_W + COL_W;
    localparam int unsigned c_LIN_W   = (c_ADDR_W > DATA_W) ? c_ADDR_W : DATA_W;
    localparam int unsigned c_J_SHIFT = $clog2(BURST_LEN);
    localparam int unsigned c_J_W     = (BURST_LEN > 1) ? c_J_SHIFT : 1;
    localparam int unsigned c_BI_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int unsigned c_TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_BI_W-1:0]  c_LAST_BURST = c_BI_W'(NUM_BURSTS - 1);
    localparam logic [c_J_W-1:0]   c_LAST_WORD  = c_J_W'(BURST_LEN - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST   = c_TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state_q,    w_state_d;
    logic [c_BI_W-1:0]     r_burst_q,    w_burst_d;
    logic [c_J_W-1:0]      r_word_q,     w_word_d;
    logic [c_TMO_W-1:0]    r_tmo_q,      w_tmo_d;
    logic                  r_rd_after_q, w_rd_after_d;
    logic [15:0]           r_err_q,      w_err_d;
    logic [c_ADDR_W-1:0]   r_first_q,    w_first_d;
    logic                  r_timeout_q,  w_timeout_d;

    logic                  w_accept;
    logic                  w_tmo_hit;
    logic [c_LIN_W-1:0]    w_base;
    logic [c_LIN_W-1:0]    w_lin;
    logic [DATA_W-1:0]     w_mask;
    logic [DATA_W-1:0]     w_exp;

    assign w_accept  = start && ((r_state_q == S_IDLE) || (r_state_q == S_DONE));
    assign w_tmo_hit = (r_tmo_q == c_TMO_LAST);

    // Burst start is b*BURST_LEN; the word index fills the low bits.
    assign w_base = c_LIN_W'(r_burst_q) << c_J_SHIFT;
    assign w_lin  = w_base | c_LIN_W'(r_word_q);
    assign w_exp  = w_lin[DATA_W-1:0] ^ w_mask;

`ifdef SDRAM_TG_INVERT_EN
    logic r_inv_q, w_inv_d;

    always_comb begin
        w_inv_d = r_inv_q;
        if (w_accept) begin
            w_inv_d = invert;
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            r_inv_q <= 1'b0;
        end else begin
            r_inv_q <= w_inv_d;
        end
    end

    assign w_mask = {DATA_W{r_inv_q}};
`else
    logic w_unused_invert;
    assign w_unused_invert = invert;
    assign w_mask          = '0;
`endif

    always_comb begin
        w_state_d    = r_state_q;
        w_burst_d    = r_burst_q;
        w_word_d     = r_word_q;
        w_tmo_d      = r_tmo_q;
        w_rd_after_d = r_rd_after_q;
        w_err_d      = r_err_q;
        w_first_d    = r_first_q;
        w_timeout_d  = r_timeout_q;

        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_d    = (mode == 2'd1) ? S_RD : S_WR;
                    w_rd_after_d = (mode != 2'd0);
                    w_burst_d    = '0;
                    w_word_d     = '0;
                    w_tmo_d      = '0;
                    w_err_d      = '0;
                    w_first_d    = '0;
                    w_timeout_d  = 1'b0;
                end
            end

            S_WR: begin
                if (mem.wr_ack) begin
                    w_tmo_d = '0;
                    if (r_burst_q == c_LAST_BURST) begin
                        w_burst_d = '0;
                        w_state_d = r_rd_after_q ? S_RD : S_DONE;
                    end else begin
                        w_burst_d = r_burst_q + c_BI_W'(1);
                    end
                end else if (w_tmo_hit) begin
                    w_timeout_d = 1'b1;
                    w_state_d   = S_DONE;
                end else begin
                    w_tmo_d = r_tmo_q + c_TMO_W'(1);
                end
            end

            S_RD: begin
                if (mem.rd_valid) begin
                    w_tmo_d = '0;
                    if (mem.rd_data != w_exp) begin
                        // A zero count means this is the first mismatch of the pass.
                        if (r_err_q == 16'd0) begin
                            w_first_d = w_lin[c_ADDR_W-1:0];
                        end
                        if (r_err_q != 16'hFFFF) begin
                            w_err_d = r_err_q + 16'd1;
                        end
                    end
                    if (r_word_q == c_LAST_WORD) begin
                        w_word_d = '0;
                        if (r_burst_q == c_LAST_BURST) begin
                            w_burst_d = '0;
                            w_state_d = S_DONE;
                        end else begin
                            w_burst_d = r_burst_q + c_BI_W'(1);
                        end
                    end else begin
                        w_word_d = r_word_q + c_J_W'(1);
                    end
                end else if (w_tmo_hit) begin
                    w_timeout_d = 1'b1;
                    w_state_d   = S_DONE;
                end else begin
                    w_tmo_d = r_tmo_q + c_TMO_W'(1);
                end
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            r_state_q    <= S_IDLE;
            r_burst_q    <= '0;
            r_word_q     <= '0;
            r_tmo_q      <= '0;
            r_rd_after_q <= 1'b0;
            r_err_q      <= '0;
            r_first_q    <= '0;
            r_timeout_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_burst_q    <= w_burst_d;
            r_word_q     <= w_word_d;
            r_tmo_q      <= w_tmo_d;
            r_rd_after_q <= w_rd_after_d;
            r_err_q      <= w_err_d;
            r_first_q    <= w_first_d;
            r_timeout_q  <= w_timeout_d;
        end
    end

    assign {mem.ba, mem.row, mem.col} = w_base[c_ADDR_W-1:0];
    assign mem.wr_req = (r_state_q == S_WR);
    assign mem.rd_req = (r_state_q == S_RD);

    // Burst data is only driven while writing so it reads as zero otherwise.
    generate
        for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_wr_word
            logic [DATA_W-1:0] w_word_lin;
            assign w_word_lin = DATA_W'(w_base) + DATA_W'(gi);
            assign mem.wr_data[gi*DATA_W +: DATA_W] =
                (r_state_q == S_WR) ? (w_word_lin ^ w_mask) : '0;
        end
    endgenerate

    assign busy           = (r_state_q == S_WR) || (r_state_q == S_RD);
    assign done           = (r_state_q == S_DONE);
    assign pass           = done && (r_err_q == 16'd0) && !r_timeout_q;
    assign timeout        = r_timeout_q;
    assign err_cnt        = r_err_q;
    assign first_err_addr = r_first_q;

endmodule
`default_nettype wire
